apb2_arbiter: RTL and testbench

APB2_ARBITER -- requirements
Module: apb2_arbiter

---
 rtl/apb2_arbiter_pkg.sv | 14 +
 rtl/apb2_arbiter_rr.sv | 28 ++
 rtl/apb2_arbiter.sv | 114 +++++++++++
 tb/tb_apb2_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb2_arbiter_pkg.sv
// Shared APB2 master definitions: FSM state encodings and a pointer-width helper,
// kept here so other APB2 masters can reuse the same encodings.
package apb2_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ENABLE = 2'd2;

    // A single requester still needs a one-bit pointer.
    function automatic int ptr_bits(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb2_arbiter_rr.sv
// Combinational round-robin selector: one-hot grant of the first request found
// searching upward from (pointer + 1), wrapping to index 0.
module rr_priority_select
    import apb2_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_bits(N)
) (
    input  logic [N-1:0]  request,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [N-1:0] above_ptr;
    logic [N-1:0] masked;
    logic [N-1:0] pick;

    // Prefer requests strictly above the pointer; otherwise wrap and take the lowest one.
    always_comb begin
        above_ptr = ~((N'(2) << pointer) - N'(1));
        masked    = request & above_ptr;
        pick      = (|masked) ? masked : request;
        grant     = pick & (~pick + N'(1));
        valid     = |request;
    end

endmodule

// File: rtl/apb2_arbiter.sv
// Round-robin arbiter letting several requesters share one APB2 master port.
// Two-cycle transfers; a different requester can follow with no idle cycle.
module apb2_arbiter
    import apb2_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 9
) (
    input  logic                            PCLK,
    input  logic                            PRESETn,
    input  logic [REQUESTERS-1:0]           req,
    input  logic [REQUESTERS-1:0]           write,
    input  logic [REQUESTERS*ADDR_BITS-1:0] addr,
    input  logic [REQUESTERS*DATA_BITS-1:0] wdata,
    output logic [REQUESTERS-1:0]           done,
    output logic [DATA_BITS-1:0]            rdata,
    output logic                            PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [ADDR_BITS-1:0]            PADDR,
    output logic [DATA_BITS-1:0]            PWDATA,
    input  logic [DATA_BITS-1:0]            PRDATA
);

    localparam int PW = ptr_bits(REQUESTERS);

    logic [1:0]            state;
    logic [PW-1:0]         rr_ptr;
    logic [REQUESTERS-1:0] cur_grant;
    logic [REQUESTERS-1:0] arb_req;
    logic [REQUESTERS-1:0] next_grant;
    logic                  next_valid;
    logic [PW-1:0]         next_idx;
    logic                  next_write;
    logic [ADDR_BITS-1:0]  next_addr;
    logic [DATA_BITS-1:0]  next_wdata;

    // The finishing requester sits out the back-to-back decision, so a repeat costs one IDLE cycle.
    assign arb_req = (state == ST_ENABLE) ? (req & ~cur_grant) : req;

    rr_priority_select #(
        .N  (REQUESTERS),
        .PW (PW)
    ) u_select (
        .request (arb_req),
        .pointer (rr_ptr),
        .grant   (next_grant),
        .valid   (next_valid)
    );

    always_comb begin
        next_idx   = '0;
        next_write = 1'b0;
        next_addr  = '0;
        next_wdata = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (next_grant[i]) begin
                next_idx   = PW'(i);
                next_write = write[i];
                next_addr  = addr[i*ADDR_BITS +: ADDR_BITS];
                next_wdata = wdata[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign rdata = (state == ST_ENABLE) ? PRDATA : '0;

    // IDLE and ENABLE both arbitrate; SETUP always advances to ENABLE.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= ST_IDLE;
            rr_ptr    <= PW'(REQUESTERS - 1);
            cur_grant <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            done      <= '0;
        end else begin
            case (state)
                ST_SETUP: begin
                    state   <= ST_ENABLE;
                    PENABLE <= 1'b1;
                    done    <= cur_grant;
                end
                ST_IDLE, ST_ENABLE: begin
                    done    <= '0;
                    PENABLE <= 1'b0;
                    if (next_valid) begin
                        state     <= ST_SETUP;
                        PSEL      <= 1'b1;
                        cur_grant <= next_grant;
                        rr_ptr    <= next_idx;
                        PWRITE    <= next_write;
                        PADDR     <= next_addr;
                        PWDATA    <= next_wdata;
                    end else begin
                        state <= ST_IDLE;
                        PSEL  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    done    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb2_arbiter.sv
// Bench for apb2_arbiter: per-requester scoreboards plus a cycle-level reference of
// the round-robin schedule, with a 32-peripheral slave mux modelled behind PADDR[4:0].
module tb_apb2_arbiter;

    localparam int N  = 4;
    localparam int AB = 8;
    localparam int DB = 9;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b0;
    logic [N-1:0]    req;
    logic [N-1:0]    write;
    logic [N*AB-1:0] addr;
    logic [N*DB-1:0] wdata;
    logic [N-1:0]    done;
    logic [DB-1:0]   rdata;
    logic            PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [AB-1:0]   PADDR;
    logic [DB-1:0]   PWDATA;
    logic [DB-1:0]   PRDATA;

    typedef struct packed {
        logic          wr;
        logic [AB-1:0] a;
        logic [DB-1:0] d;
        logic [DB-1:0] rd;
    } xfer_t;

    xfer_t stim_q[N][$];
    xfer_t exp_q[N][$];

    int checks = 0;
    int failures = 0;

    // Reference schedule: cycles into the current transfer (0 idle, 1 setup, 2 enable).
    int m_age = 0;
    int m_g = 0;
    int m_last = N - 1;
    bit m_reset_prev = 1'b1;

    apb2_arbiter #(
        .REQUESTERS (N),
        .ADDR_BITS  (AB),
        .DATA_BITS  (DB)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .req     (req),
        .write   (write),
        .addr    (addr),
        .wdata   (wdata),
        .done    (done),
        .rdata   (rdata),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    // Peripheral k of the slave mux returns a distinct word; peripheral 5 gives 9'h1A5.
    function automatic logic [DB-1:0] periph_data(logic [4:0] sel);
        int v;
        v = (int'(sel) * 13 + 356) % 512;
        return DB'(v);
    endfunction

    assign PRDATA = periph_data(PADDR[4:0]);

    function automatic int rr_pick(logic [N-1:0] elig, int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (elig[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit busy();
        for (int i = 0; i < N; i++)
            if (stim_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #2;
    endtask

    task automatic load(int i);
        if (stim_q[i].size() != 0) begin
            write[i]              = stim_q[i][0].wr;
            addr[i*AB +: AB]      = stim_q[i][0].a;
            wdata[i*DB +: DB]     = stim_q[i][0].d;
            req[i]                = 1'b1;
        end else begin
            req[i] = 1'b0;
        end
    endtask

    task automatic apply_stimulus(int i, logic wr, logic [AB-1:0] a, logic [DB-1:0] d);
        xfer_t x;
        x.wr = wr;
        x.a  = a;
        x.d  = d;
        x.rd = periph_data(a[4:0]);
        stim_q[i].push_back(x);
        exp_q[i].push_back(x);
        if (stim_q[i].size() == 1) load(i);
    endtask

    // A requester may give up only while it is not the one being served.
    task automatic withdraw(int i);
        if (stim_q[i].size() != 0 && !(m_age != 0 && m_g == i)) begin
            void'(stim_q[i].pop_front());
            void'(exp_q[i].pop_front());
            load(i);
        end
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while ((busy() || m_age != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (busy() || m_age != 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout: pending work after %0d cycles at %0t", budget, $time);
        end
    endtask

    // Requester agents: retire the head transaction on its done pulse and present the next one.
    initial begin
        req   = '0;
        write = '0;
        addr  = '0;
        wdata = '0;
        forever begin
            @(posedge PCLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (done[i] && stim_q[i].size() != 0) begin
                    void'(stim_q[i].pop_front());
                    load(i);
                end
            end
        end
    end

    // Monitor: checks controls against the reference schedule, pops scoreboards on done.
    initial begin
        logic [N-1:0] exp_done;
        logic [N-1:0] elig;
        int gi;
        xfer_t e;
        @(posedge PCLK);
        forever begin
            @(negedge PCLK);
            exp_done = '0;
            if (m_age == 2) exp_done[m_g] = 1'b1;
            check_output("psel", 32'(PSEL), 32'(m_age != 0));
            check_output("penable", 32'(PENABLE), 32'(m_age == 2));
            check_output("done", 32'(done), 32'(exp_done));
            if (m_reset_prev) begin
                check_output("reset_paddr", 32'(PADDR), 32'd0);
                check_output("reset_pwdata", 32'(PWDATA), 32'd0);
                check_output("reset_pwrite", 32'(PWRITE), 32'd0);
            end
            if (m_age == 1 && exp_q[m_g].size() != 0) begin
                e = exp_q[m_g][0];
                check_output("setup_paddr", 32'(PADDR), 32'(e.a));
                check_output("setup_pwrite", 32'(PWRITE), 32'(e.wr));
                check_output("setup_pwdata", 32'(PWDATA), 32'(e.d));
            end
            if (done != '0) begin
                gi = 0;
                for (int i = 0; i < N; i++)
                    if (done[i]) gi = i;
                checks++;
                if (exp_q[gi].size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_done: got done=%b with nothing expected at %0t", done, $time);
                end else begin
                    e = exp_q[gi].pop_front();
                    check_output("enable_paddr", 32'(PADDR), 32'(e.a));
                    check_output("enable_pwrite", 32'(PWRITE), 32'(e.wr));
                    check_output("enable_pwdata", 32'(PWDATA), 32'(e.d));
                    check_output("rdata", 32'(rdata), 32'(e.rd));
                end
            end
            if (!PRESETn) begin
                m_age = 0;
                m_last = N - 1;
                m_reset_prev = 1'b1;
            end else begin
                m_reset_prev = 1'b0;
                if (m_age == 1) begin
                    m_age = 2;
                end else begin
                    elig = req;
                    if (m_age == 2) elig[m_g] = 1'b0;
                    gi = rr_pick(elig, m_last);
                    if (gi >= 0) begin
                        m_g = gi;
                        m_last = gi;
                        m_age = 1;
                    end else begin
                        m_age = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish at %0t", $time);
        $fatal(1, "[TB] aborted");
    end

    initial begin
        int n;
        int i;
        int r;
        PRESETn = 1'b0;
        repeat (3) tick();
        PRESETn = 1'b1;
        tick();

        $display("[TB] single read from requester 0");
        apply_stimulus(0, 1'b0, 8'h05, 9'h000);
        wait_idle(20);

        $display("[TB] single write from requester 2");
        apply_stimulus(2, 1'b1, 8'h10, 9'h0F3);
        wait_idle(20);

        $display("[TB] fairness with all requesters");
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
        apply_stimulus(0, 1'b0, 8'h01, 9'h011);
        apply_stimulus(1, 1'b1, 8'h02, 9'h022);
        apply_stimulus(2, 1'b0, 8'h03, 9'h033);
        apply_stimulus(3, 1'b1, 8'h04, 9'h044);
        apply_stimulus(0, 1'b1, 8'h06, 9'h066);
        wait_idle(40);

        $display("[TB] same requester back to back");
        apply_stimulus(1, 1'b0, 8'h07, 9'h0AA);
        apply_stimulus(1, 1'b1, 8'h08, 9'h155);
        wait_idle(20);

        $display("[TB] reset during enable of requester 3");
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
        apply_stimulus(3, 1'b0, 8'h09, 9'h0C3);
        n = 0;
        while (!done[3] && n < 10) begin
            tick();
            n++;
        end
        check_output("reach_enable3", 32'(done[3]), 32'd1);
        PRESETn = 1'b0;
        apply_stimulus(0, 1'b0, 8'h0A, 9'h001);
        apply_stimulus(3, 1'b1, 8'h0B, 9'h002);
        tick();
        PRESETn = 1'b1;
        wait_idle(30);

        $display("[TB] reading all 32 peripherals");
        for (int k = 0; k < 32; k++)
            apply_stimulus(k % N, 1'b0, {3'($urandom), 5'(k)}, 9'($urandom));
        wait_idle(400);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            tick();
            r = $urandom_range(0, 99);
            i = $urandom_range(0, N - 1);
            if (r < 30) begin
                if (stim_q[i].size() < 3)
                    apply_stimulus(i, 1'($urandom), 8'($urandom), 9'($urandom));
            end else if (r < 34) begin
                withdraw(i);
            end else if (r == 34) begin
                PRESETn = 1'b0;
                tick();
                PRESETn = 1'b1;
            end
        end
        wait_idle(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
